craft_tweakey_gen: RTL and testbench

- Sequential CRAFT round-tweakey generator.
- Accepts one 128-bit key and one 64-bit tweak per block through a valid/ready handshake.
- Streams the ROUNDS round tweakeys TK(0..ROUNDS-1) in order through a second valid/ready handshake.
- Sits between the key/tweak input registers and the round datapath; precomputes Q(tweak) once per block instead of per round.

---
 rtl/craft_pkg.sv | 26 ++
 rtl/craft_tweakey_gen_if.sv | 37 +++
 rtl/craft_tk_mux.sv | 15 +
 rtl/craft_tweakey_gen.sv | 118 +++++++++++
 tb/tb_craft_tweakey_gen.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/craft_pkg.sv
// Shared constants, state type and the CRAFT tweak nibble permutation Q
// used by the round-tweakey generator.
package craft_pkg;

  localparam int BLK_W   = 64;
  localparam int KEY_W   = 128;
  localparam int NIBBLES = 16;

  // Output nibble i takes input nibble Q_TABLE[i]; nibble 0 is the MSB nibble.
  localparam int Q_TABLE [NIBBLES] = '{12, 10, 15, 5, 14, 8, 9, 2, 11, 3, 7, 4, 6, 0, 1, 13};

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic [BLK_W-1:0] q_perm(input logic [BLK_W-1:0] t);
    logic [BLK_W-1:0] q;
    q = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      q[BLK_W-1-4*i -: 4] = t[BLK_W-1-4*Q_TABLE[i] -: 4];
    end
    return q;
  endfunction

endpackage

// File: rtl/craft_tweakey_gen_if.sv
// Key/tweak input handshake and round-tweakey output handshake of the
// CRAFT tweakey generator. CRAFT_TKGEN_DECRYPT_EN adds the dec select.
interface craft_tweakey_gen_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [127:0]     key;
  logic [63:0]      tweak;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      tk;
  logic [CNT_W-1:0] round;
  logic             last;
  logic             abort;
`ifdef CRAFT_TKGEN_DECRYPT_EN
  logic             dec;

  modport master (
    output in_valid, key, tweak, out_ready, abort, dec,
    input  in_ready, out_valid, tk, round, last
  );
  modport slave (
    input  in_valid, key, tweak, out_ready, abort, dec,
    output in_ready, out_valid, tk, round, last
  );
`else
  modport master (
    output in_valid, key, tweak, out_ready, abort,
    input  in_ready, out_valid, tk, round, last
  );
  modport slave (
    input  in_valid, key, tweak, out_ready, abort,
    output in_ready, out_valid, tk, round, last
  );
`endif
endinterface

// File: rtl/craft_tk_mux.sv
// Combinational round-tweakey select: key half by r[0], T or Q(T) by r[1].
module craft_tk_mux
  import craft_pkg::*;
(
  input  logic [BLK_W-1:0] k0,
  input  logic [BLK_W-1:0] k1,
  input  logic [BLK_W-1:0] t,
  input  logic [BLK_W-1:0] qt,
  input  logic [1:0]       rsel,
  output logic [BLK_W-1:0] tk
);

  assign tk = (rsel[0] ? k1 : k0) ^ (rsel[1] ? qt : t);

endmodule

// File: rtl/craft_tweakey_gen.sv
// Sequential CRAFT round-tweakey generator streaming TK(0..ROUNDS-1) per block.
// Optional macro CRAFT_TKGEN_DECRYPT_EN adds descending (decrypt) round order.
module craft_tweakey_gen
  import craft_pkg::*;
#(
  parameter int ROUNDS = 32,
  parameter int CNT_W  = 8
) (
  input logic               clk,
  input logic               rst_n,
  craft_tweakey_gen_if.slave bus
);

  state_t           state_p0, state_d;
  logic [CNT_W-1:0] cnt_p0, cnt_d;
  logic [BLK_W-1:0] tk_p0, tk_d;
  logic [BLK_W-1:0] k0_p0, k1_p0, t_p0, qt_p0;
  logic [BLK_W-1:0] mk0, mk1, mt, mqt;
  logic             accept, xfer, load_tk;
  logic             dec_in, dec_p0;
  logic [CNT_W-1:0] start_idx, last_idx;

`ifdef CRAFT_TKGEN_DECRYPT_EN
  assign dec_in = bus.dec;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dec_p0 <= 1'b0;
    end else if (accept && !bus.abort) begin
      dec_p0 <= bus.dec;
    end
  end
`else
  assign dec_in = 1'b0;
  assign dec_p0 = 1'b0;
`endif

  assign start_idx = dec_in ? CNT_W'(ROUNDS - 1) : '0;
  assign last_idx  = dec_p0 ? '0 : CNT_W'(ROUNDS - 1);

  assign accept = (state_p0 == IDLE) && bus.in_valid;
  assign xfer   = (state_p0 == RUN) && bus.out_ready;

  always_comb begin
    state_d = state_p0;
    cnt_d   = cnt_p0;
    load_tk = 1'b0;
    if (bus.abort) begin
      state_d = IDLE;
    end else if (accept) begin
      state_d = RUN;
      cnt_d   = start_idx;
      load_tk = 1'b1;
    end else if (xfer) begin
      if (cnt_p0 == last_idx) begin
        state_d = IDLE;
      end else begin
        cnt_d   = dec_p0 ? cnt_p0 - CNT_W'(1) : cnt_p0 + CNT_W'(1);
        load_tk = 1'b1;
      end
    end
  end

  // On the accept edge the key/tweak registers are not yet loaded, so the
  // first tweakey is built straight from the inputs.
  always_comb begin
    mk0 = k0_p0;
    mk1 = k1_p0;
    mt  = t_p0;
    mqt = qt_p0;
    if (accept) begin
      mk0 = bus.key[127:64];
      mk1 = bus.key[63:0];
      mt  = bus.tweak;
      mqt = q_perm(bus.tweak);
    end
  end

  craft_tk_mux u_tk_mux (
    .k0   (mk0),
    .k1   (mk1),
    .t    (mt),
    .qt   (mqt),
    .rsel (2'(cnt_d)),
    .tk   (tk_d)
  );

  // ---- stage p0: control state and tweakey register ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_p0 <= IDLE;
      cnt_p0   <= '0;
      tk_p0    <= '0;
    end else begin
      state_p0 <= state_d;
      cnt_p0   <= cnt_d;
      if (load_tk) begin
        tk_p0 <= tk_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !bus.abort && rst_n) begin
      k0_p0 <= bus.key[127:64];
      k1_p0 <= bus.key[63:0];
      t_p0  <= bus.tweak;
      qt_p0 <= q_perm(bus.tweak);
    end
  end

  assign bus.in_ready  = (state_p0 == IDLE);
  assign bus.out_valid = (state_p0 == RUN);
  assign bus.last      = (state_p0 == RUN) && (cnt_p0 == last_idx);
  assign bus.tk        = tk_p0;
  assign bus.round     = cnt_p0;

endmodule

// File: tb/tb_craft_tweakey_gen.sv
// Self-checking bench for craft_tweakey_gen: vector table, random blocks with
// backpressure, abort and mid-block reset; decrypt order under CRAFT_TKGEN_DECRYPT_EN.
module tb_craft_tweakey_gen;

  localparam int ROUNDS = 32;
  localparam int CNT_W  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  craft_tweakey_gen_if #(.CNT_W(CNT_W)) bus ();

  craft_tweakey_gen #(.ROUNDS(ROUNDS), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: Q as a nibble gather, then the round rule by plain arithmetic.
  localparam int QP [16] = '{12, 10, 15, 5, 14, 8, 9, 2, 11, 3, 7, 4, 6, 0, 1, 13};

  function automatic logic [63:0] model_q(input logic [63:0] t);
    logic [3:0]  n [16];
    logic [63:0] q;
    q = 64'd0;
    for (int i = 0; i < 16; i++) n[i] = t[63-4*i -: 4];
    for (int i = 0; i < 16; i++) q = (q << 4) | 64'(n[QP[i]]);
    return q;
  endfunction

  function automatic logic [63:0] model_tk(input logic [127:0] key, input logic [63:0] tweak, input int r);
    logic [63:0] kh, tt;
    kh = (r % 2 == 0) ? key[127:64] : key[63:0];
    tt = ((r / 2) % 2 == 0) ? tweak : model_q(tweak);
    return kh ^ tt;
  endfunction

  logic [63:0] cap_tk [ROUNDS];
  logic [63:0] ref_tk [ROUNDS];

  task automatic set_dec(input logic d);
`ifdef CRAFT_TKGEN_DECRYPT_EN
    bus.dec = d;
`else
    if (d) chk("dec_unsupported", 64'(d), 64'(0));
`endif
  endtask

  task automatic offer(input logic [127:0] key, input logic [63:0] tweak, input logic d);
    int cyc;
    cyc = 0;
    while (bus.in_ready !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (bus.in_ready !== 1'b1) chk("in_ready_timeout", 64'(bus.in_ready), 64'(1));
    bus.key = key;
    bus.tweak = tweak;
    set_dec(d);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.key = {$urandom(), $urandom(), $urandom(), $urandom()};
    bus.tweak = {$urandom(), $urandom()};
    set_dec(1'b0);
    chk("accept_latency", 64'(bus.out_valid), 64'(1));
  endtask

  task automatic run_block(input logic [127:0] key, input logic [63:0] tweak,
                           input int stall_pct, input logic d);
    int k, cyc, idx;
    logic held;
    logic [63:0] htk;
    logic [CNT_W-1:0] hround;
    logic hlast;
    k = 0;
    cyc = 0;
    held = 1'b0;
    htk = '0;
    hround = '0;
    hlast = 1'b0;
    bus.out_ready = 1'b0;
    offer(key, tweak, d);
    while (k < ROUNDS && cyc < 2000) begin
      bus.out_ready = ($urandom_range(99) >= stall_pct);
      if (held) begin
        chk("stall_tk", bus.tk, htk);
        chk("stall_round", 64'(bus.round), 64'(hround));
        chk("stall_last", 64'(bus.last), 64'(hlast));
      end
      idx = d ? ROUNDS - 1 - k : k;
      if (bus.out_valid !== 1'b1) begin
        chk("out_valid_in_block", 64'(bus.out_valid), 64'(1));
        cyc = 2000;
      end else if (bus.out_ready) begin
        chk("tk", bus.tk, model_tk(key, tweak, idx));
        chk("round", 64'(bus.round), 64'(idx));
        chk("last", 64'(bus.last), 64'(k == ROUNDS - 1));
        cap_tk[idx] = bus.tk;
        k++;
        held = 1'b0;
      end else begin
        held = 1'b1;
        htk = bus.tk;
        hround = bus.round;
        hlast = bus.last;
      end
      @(negedge clk);
      cyc++;
    end
    bus.out_ready = 1'b0;
    if (k < ROUNDS) chk("block_timeout", 64'(k), 64'(ROUNDS));
    if (stall_pct == 0) chk("back_to_back_cycles", 64'(cyc), 64'(ROUNDS));
    chk("idle_after_block", {62'd0, bus.in_ready, bus.out_valid}, 64'b10);
  endtask

  task automatic advance_to(input int target);
    int cyc;
    cyc = 0;
    bus.out_ready = 1'b1;
    while (int'(bus.round) != target && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    bus.out_ready = 1'b0;
    chk("reach_round", 64'(bus.round), 64'(target));
  endtask

  typedef struct {
    logic [127:0] key;
    logic [63:0]  tweak;
    int           r;
    logic [63:0]  exp;
  } vec_t;

  localparam logic [127:0] KEY1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [63:0]  TW1  = 64'h0123456789abcdef;

  vec_t vt [12];

  initial begin
    logic [127:0] rk;
    logic [63:0]  rt;

    vt[0]  = '{KEY1,   TW1, 0,  64'h01326754cdfeab98};
    vt[1]  = '{KEY1,   TW1, 1,  64'h89baefdc45762310};
    vt[2]  = '{KEY1,   TW1, 2,  64'hcae4caa1f721066a};
    vt[3]  = '{KEY1,   TW1, 31, 64'h426c42297fa98ee2};
    vt[4]  = '{128'd0, TW1, 0,  64'h0123456789abcdef};
    vt[5]  = '{128'd0, TW1, 1,  64'h0123456789abcdef};
    vt[6]  = '{128'd0, TW1, 2,  64'hcaf5e892b374601d};
    vt[7]  = '{128'd0, TW1, 3,  64'hcaf5e892b374601d};
    vt[8]  = '{128'd0, TW1, 4,  64'h0123456789abcdef};
    vt[9]  = '{128'd0, TW1, 29, 64'h0123456789abcdef};
    vt[10] = '{128'd0, TW1, 30, 64'hcaf5e892b374601d};
    vt[11] = '{128'd0, TW1, 31, 64'hcaf5e892b374601d};

    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.abort = 1'b0;
    bus.key = '0;
    bus.tweak = '0;
    set_dec(1'b0);

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", 64'(bus.in_ready), 64'(1));
    chk("reset_out_valid", 64'(bus.out_valid), 64'(0));
    chk("reset_tk", bus.tk, 64'd0);
    chk("reset_round", 64'(bus.round), 64'(0));
    chk("reset_last", 64'(bus.last), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      run_block(vt[i].key, vt[i].tweak, 0, 1'b0);
      chk($sformatf("vec%0d_r%0d", i, vt[i].r), cap_tk[vt[i].r], vt[i].exp);
    end

    // Backpressured run must reproduce the stall-free sequence.
    run_block(KEY1, TW1, 0, 1'b0);
    for (int i = 0; i < ROUNDS; i++) ref_tk[i] = cap_tk[i];
    run_block(KEY1, TW1, 50, 1'b0);
    for (int i = 0; i < ROUNDS; i++) chk($sformatf("stall_seq_r%0d", i), cap_tk[i], ref_tk[i]);

    for (int b = 0; b < 6; b++) begin
      rk = {$urandom(), $urandom(), $urandom(), $urandom()};
      rt = {$urandom(), $urandom()};
      run_block(rk, rt, 50, 1'b0);
    end

    // Abort at round 5 together with out_ready.
    bus.out_ready = 1'b0;
    offer(KEY1, TW1, 1'b0);
    advance_to(5);
    bus.out_ready = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    bus.out_ready = 1'b1;
    chk("abort_out_valid", 64'(bus.out_valid), 64'(0));
    chk("abort_in_ready", 64'(bus.in_ready), 64'(1));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_round6", 64'(bus.out_valid), 64'(0));
    end
    bus.out_ready = 1'b0;
    run_block(KEY1, TW1, 0, 1'b0);

    // Reset asserted at round 10 with in_valid held high.
    offer(KEY1, TW1, 1'b0);
    advance_to(10);
    rk = {$urandom(), $urandom(), $urandom(), $urandom()};
    rt = {$urandom(), $urandom()};
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.key = rk;
    bus.tweak = rt;
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_tk", bus.tk, 64'd0);
    chk("rst_round", 64'(bus.round), 64'(0));
    chk("rst_last", 64'(bus.last), 64'(0));
    @(negedge clk);
    chk("rst_hold_no_accept", 64'(bus.out_valid), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("post_rst_accept", 64'(bus.out_valid), 64'(1));
    chk("post_rst_round", 64'(bus.round), 64'(0));
    chk("post_rst_tk", bus.tk, model_tk(rk, rt, 0));
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("post_rst_abort", 64'(bus.out_valid), 64'(0));

`ifdef CRAFT_TKGEN_DECRYPT_EN
    run_block(KEY1, TW1, 0, 1'b1);
    chk("dec_first_tk31", cap_tk[31], 64'h426c42297fa98ee2);
    chk("dec_last_tk0", cap_tk[0], 64'h01326754cdfeab98);
    rk = {$urandom(), $urandom(), $urandom(), $urandom()};
    rt = {$urandom(), $urandom()};
    run_block(rk, rt, 50, 1'b1);
    run_block(rk, rt, 0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
